// File: rtl/pixel_ctrl_pkg.sv
// Shared definitions for the multi-player OLED pixel controller.
//   - RGB565 colour constants (player colours, grey, black)
//   - life-state enum for the per-player FSM
//   - OLED geometry and coordinate widths
//   - player_colour(): player index -> RGB565
package pixel_ctrl_pkg;

  localparam logic [15:0] COL_P0    = 16'h07E0;
  localparam logic [15:0] COL_P1    = 16'h001F;
  localparam logic [15:0] COL_P2    = 16'hFFE0;
  localparam logic [15:0] COL_P3    = 16'hF81F;
  localparam logic [15:0] COL_GREY  = 16'h8410;
  localparam logic [15:0] COL_BLACK = 16'h0000;

  localparam int unsigned OLED_W    = 96;
  localparam int unsigned OLED_H    = 64;
  localparam int unsigned COORD_W   = 8;
  localparam int unsigned PIX_IDX_W = 13;

  typedef enum logic [1:0] {
    ALIVE,
    DOWN,
    REVIVING
  } life_t;

  function automatic logic [15:0] player_colour(input int unsigned idx);
    case (idx)
      0:       return COL_P0;
      1:       return COL_P1;
      2:       return COL_P2;
      3:       return COL_P3;
      default: return COL_P0;
    endcase
  endfunction

endpackage

// File: rtl/player_sprite.sv
// One player's sprite: position registers with edge clamping, the
// ALIVE/DOWN/REVIVING life FSM with its revive frame counter, and a
// combinational "covers the current pixel" flag.
// Ports:
//   i_clk, i_reset        pixel clock, synchronous active-high reset
//   i_step                movement tick
//   i_frame_end           last pixel of the frame is on the bus this cycle
//   i_btn_*               debounced direction buttons for this player
//   i_hit                 one-cycle knock-down pulse
//   i_revive_ok           an ALIVE teammate overlaps us and holds revive
//   i_px, i_py            current scan coordinate
//   o_covers              sprite covers (i_px, i_py)
//   o_alive/o_down/o_reviving  decoded life state
module player_sprite
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned PLAYER_IDX    = 0,
  parameter int unsigned SPRITE_SZ     = 8,
  parameter int unsigned DISP_W        = OLED_W,
  parameter int unsigned DISP_H        = OLED_H,
  parameter int unsigned REVIVE_FRAMES = 120
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_frame_end,
  input  logic               i_btn_up,
  input  logic               i_btn_down,
  input  logic               i_btn_left,
  input  logic               i_btn_right,
  input  logic               i_hit,
  input  logic               i_revive_ok,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  output logic               o_covers,
  output logic               o_alive,
  output logic               o_down,
  output logic               o_reviving
);

  localparam int unsigned RCNT_W = $clog2(REVIVE_FRAMES + 1);
  localparam logic [COORD_W-1:0] X_START = COORD_W'(4 + 16 * PLAYER_IDX);
  localparam logic [COORD_W-1:0] Y_START = COORD_W'((DISP_H - SPRITE_SZ) / 2);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(DISP_W - SPRITE_SZ);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(DISP_H - SPRITE_SZ);
  localparam logic [RCNT_W-1:0]  RCNT_LAST = RCNT_W'(REVIVE_FRAMES);

  logic [COORD_W-1:0] r_x, r_y;
  life_t              r_state, w_state_nxt;
  logic [RCNT_W-1:0]  r_rcnt, w_rcnt_nxt;
  logic [COORD_W:0]   w_x_end, w_y_end;

  // Position: only ALIVE players move; opposing buttons cancel, edges saturate.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x <= X_START;
      r_y <= Y_START;
    end else if (i_step && r_state == ALIVE) begin
      if (i_btn_right && !i_btn_left && r_x < X_MAX)
        r_x <= r_x + 1'b1;
      else if (i_btn_left && !i_btn_right && r_x > '0)
        r_x <= r_x - 1'b1;
      if (i_btn_down && !i_btn_up && r_y < Y_MAX)
        r_y <= r_y + 1'b1;
      else if (i_btn_up && !i_btn_down && r_y > '0)
        r_y <= r_y - 1'b1;
    end
  end

  // Life FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ALIVE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // Life FSM: next state. A hit always takes priority over a frame-boundary
  // transition. The counter is checked before incrementing, so revival lands
  // REVIVE_FRAMES boundaries after entering REVIVING.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    case (r_state)
      ALIVE: begin
        if (i_hit) w_state_nxt = DOWN;
      end
      DOWN: begin
        if (!i_hit && i_frame_end && i_revive_ok) begin
          w_state_nxt = REVIVING;
          w_rcnt_nxt  = RCNT_W'(1);
        end
      end
      REVIVING: begin
        if (i_hit) begin
          w_state_nxt = DOWN;
          w_rcnt_nxt  = '0;
        end else if (i_frame_end) begin
          if (!i_revive_ok) begin
            w_state_nxt = DOWN;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == RCNT_LAST) begin
            w_state_nxt = ALIVE;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ALIVE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  // Life FSM: outputs
  always_comb begin
    o_alive    = (r_state == ALIVE);
    o_down     = (r_state == DOWN);
    o_reviving = (r_state == REVIVING);
  end

  // One extra bit so x + SPRITE_SZ cannot wrap at the right/bottom edge.
  assign w_x_end  = {1'b0, r_x} + (COORD_W + 1)'(SPRITE_SZ);
  assign w_y_end  = {1'b0, r_y} + (COORD_W + 1)'(SPRITE_SZ);
  assign o_covers = (i_px >= r_x) && ({1'b0, i_px} < w_x_end) &&
                    (i_py >= r_y) && ({1'b0, i_py} < w_y_end);

endmodule

// File: rtl/multi_player_pixel_ctrl.sv
// Multi-player OLED pixel controller. Holds NUM_PLAYERS sprites, moves them
// from per-player buttons, tracks pairwise overlap per frame, runs the
// down/revive life FSMs and composites RGB565 pixel_data (1-cycle latency).
// Ports:
//   clk6p25m, reset            pixel clock, synchronous active-high reset
//   btn_up/down/left/right     per-player debounced direction levels
//   btn_revive                 per-player revive hold
//   hit                        per-player knock-down pulse
//   pixel_index                OLED scan index
//   pixel_data                 RGB565 for the previous cycle's index
//   is_collide                 two ALIVE sprites overlapped in last frame
//   player_down/player_reviving  per-player life state
module multi_player_pixel_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned SPRITE_SZ     = 8,
  parameter int unsigned DISP_W        = OLED_W,
  parameter int unsigned DISP_H        = OLED_H,
  parameter int unsigned MOVE_DIV      = 104167,
  parameter int unsigned REVIVE_FRAMES = 120
) (
  input  logic                   clk6p25m,
  input  logic                   reset,
  input  logic [NUM_PLAYERS-1:0] btn_up,
  input  logic [NUM_PLAYERS-1:0] btn_down,
  input  logic [NUM_PLAYERS-1:0] btn_left,
  input  logic [NUM_PLAYERS-1:0] btn_right,
  input  logic [NUM_PLAYERS-1:0] btn_revive,
  input  logic [NUM_PLAYERS-1:0] hit,
  input  logic [PIX_IDX_W-1:0]   pixel_index,
  output logic [15:0]            pixel_data,
  output logic                   is_collide,
  output logic [NUM_PLAYERS-1:0] player_down,
  output logic [NUM_PLAYERS-1:0] player_reviving
);

  localparam int unsigned STEP_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  logic [STEP_W-1:0]  r_step_cnt;
  logic               w_step;
  logic               w_frame_end;
  logic [COORD_W-1:0] w_px, w_py;
  logic [3:0]         r_frame_cnt;
  logic [15:0]        r_pixel, w_pix;
  logic               r_collide, w_collide_any;

  logic [NUM_PLAYERS-1:0] w_covers, w_alive, w_down, w_reviving, w_revive_ok;
  logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0] r_ov, w_ov_full;
  logic [15:0] w_colour [NUM_PLAYERS];

  assign w_step      = (r_step_cnt == STEP_W'(MOVE_DIV - 1));
  assign w_frame_end = (pixel_index == PIX_IDX_W'(DISP_W * DISP_H - 1));
  assign w_px        = COORD_W'(32'(pixel_index) % DISP_W);
  assign w_py        = COORD_W'(32'(pixel_index) / DISP_W);

  always_ff @(posedge clk6p25m) begin
    if (reset || w_step) r_step_cnt <= '0;
    else                 r_step_cnt <= r_step_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    player_sprite #(
      .PLAYER_IDX   (g),
      .SPRITE_SZ    (SPRITE_SZ),
      .DISP_W       (DISP_W),
      .DISP_H       (DISP_H),
      .REVIVE_FRAMES(REVIVE_FRAMES)
    ) u_sprite (
      .i_clk       (clk6p25m),
      .i_reset     (reset),
      .i_step      (w_step),
      .i_frame_end (w_frame_end),
      .i_btn_up    (btn_up[g]),
      .i_btn_down  (btn_down[g]),
      .i_btn_left  (btn_left[g]),
      .i_btn_right (btn_right[g]),
      .i_hit       (hit[g]),
      .i_revive_ok (w_revive_ok[g]),
      .i_px        (w_px),
      .i_py        (w_py),
      .o_covers    (w_covers[g]),
      .o_alive     (w_alive[g]),
      .o_down      (w_down[g]),
      .o_reviving  (w_reviving[g])
    );

    // REVIVING blinks: player colour for 8 frames, grey for the next 8.
    assign w_colour[g] = (w_down[g] || (w_reviving[g] && r_frame_cnt[3]))
                         ? COL_GREY : player_colour(g);
  end

  // Overlap seen so far this frame, including the pixel on the bus now, so
  // the last pixel of the frame counts at the boundary.
  always_comb begin
    w_ov_full = r_ov;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++)
      for (int unsigned j = 0; j < NUM_PLAYERS; j++)
        if (i != j && w_covers[i] && w_covers[j]) w_ov_full[i][j] = 1'b1;
  end

  always_ff @(posedge clk6p25m) begin
    if (reset || w_frame_end) r_ov <= '0;
    else                      r_ov <= w_ov_full;
  end

  always_comb begin
    w_collide_any = 1'b0;
    w_revive_ok   = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++)
      for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
        if (i < j && w_alive[i] && w_alive[j] && w_ov_full[i][j])
          w_collide_any = 1'b1;
        if (i != j && w_alive[j] && btn_revive[j] && w_ov_full[i][j])
          w_revive_ok[i] = 1'b1;
      end
  end

  // Lowest index wins: walk from the highest so lower indices overwrite.
  always_comb begin
    w_pix = COL_BLACK;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++)
      if (w_covers[NUM_PLAYERS - 1 - k]) w_pix = w_colour[NUM_PLAYERS - 1 - k];
  end

  always_ff @(posedge clk6p25m) begin
    if (reset) begin
      r_pixel     <= COL_BLACK;
      r_collide   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_pixel <= w_pix;
      if (w_frame_end) begin
        r_collide   <= w_collide_any;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign pixel_data      = r_pixel;
  assign is_collide      = r_collide;
  assign player_down     = w_down;
  assign player_reviving = w_reviving;

endmodule

// File: tb/tb_multi_player_pixel_ctrl.sv
// Directed bench for multi_player_pixel_ctrl with MOVE_DIV=4, REVIVE_FRAMES=4.
module tb_multi_player_pixel_ctrl;

  localparam int W = 96;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] GREY  = 16'h8410;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  btn_up, btn_down, btn_left, btn_right, btn_revive, hit;
  logic [12:0] pixel_index;
  logic [15:0] pixel_data;
  logic        is_collide;
  logic [1:0]  player_down, player_reviving;

  int n_tests = 0;
  int n_fail  = 0;
  int m_frames = 0;

  always #5 clk = ~clk;

  multi_player_pixel_ctrl #(
    .NUM_PLAYERS  (2),
    .MOVE_DIV     (4),
    .REVIVE_FRAMES(4)
  ) dut (
    .clk6p25m       (clk),
    .reset          (reset),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_revive     (btn_revive),
    .hit            (hit),
    .pixel_index    (pixel_index),
    .pixel_data     (pixel_data),
    .is_collide     (is_collide),
    .player_down    (player_down),
    .player_reviving(player_reviving)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (4 * n) tick();
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [15:0] exp);
    pixel_index = 13'(y * W + x);
    tick();
    check(tag, 32'(pixel_data), 32'(exp));
    pixel_index = '0;
  endtask

  // Scan the rows holding the sprites, then jump to the last index.
  task automatic scan(input logic hit1);
    for (int idx = 24 * W; idx < 40 * W; idx++) begin
      pixel_index = 13'(idx);
      tick();
    end
    pixel_index = 13'(6143);
    hit[1] = hit1;
    tick();
    hit = '0;
    pixel_index = '0;
    m_frames++;
  endtask

  task automatic pulse_hit1();
    hit = 2'b10;
    tick();
    hit = '0;
  endtask

  function automatic logic [15:0] rev_colour();
    return ((m_frames / 8) % 2 != 0) ? GREY : BLUE;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    btn_up = '0; btn_down = '0; btn_left = '0; btn_right = '0;
    btn_revive = '0; hit = '0; pixel_index = '0;
    tick(); tick();
    check("rst_pix", 32'(pixel_data), 32'h0);
    check("rst_collide", 32'(is_collide), 32'h0);
    check("rst_down", 32'(player_down), 32'h0);
    check("rst_reviving", 32'(player_reviving), 32'h0);
    reset = 1'b0;
    tick();

    // Full frame against the reset positions
    for (int idx = 0; idx < 6144; idx++) begin
      int x, y;
      logic [15:0] e;
      x = idx % W;
      y = idx / W;
      e = 16'h0000;
      if (y >= 28 && y <= 35 && x >= 4 && x <= 11) e = GREEN;
      else if (y >= 28 && y <= 35 && x >= 20 && x <= 27) e = BLUE;
      pixel_index = 13'(idx);
      tick();
      check("frame_px", 32'(pixel_data), 32'(e));
    end
    m_frames++;
    pixel_index = '0;
    check("frame_collide", 32'(is_collide), 32'h0);

    // Latency: output holds the previous index's pixel until the next edge
    pixel_index = 13'(28 * W + 4);
    tick();
    check("lat_green", 32'(pixel_data), 32'(GREEN));
    pixel_index = 13'(28 * W + 3);
    #1;
    check("lat_hold", 32'(pixel_data), 32'(GREEN));
    tick();
    check("lat_black", 32'(pixel_data), 32'h0);
    pixel_index = '0;

    // Right edge saturation
    btn_right[0] = 1'b1; steps(400); btn_right[0] = 1'b0;
    probe("p0_x88", 88, 28, GREEN);
    probe("p0_x95", 95, 35, GREEN);
    probe("p0_x87", 87, 28, 16'h0);
    probe("p1_home", 20, 28, BLUE);
    btn_left[0] = 1'b1; btn_right[0] = 1'b1; steps(10);
    btn_left[0] = 1'b0; btn_right[0] = 1'b0;
    probe("cancel_x88", 88, 28, GREEN);
    probe("cancel_x87", 87, 28, 16'h0);

    // Bottom edge saturation and exact step count back up
    btn_down[0] = 1'b1; steps(50); btn_down[0] = 1'b0;
    probe("p0_y63", 88, 63, GREEN);
    probe("p0_y55", 88, 55, 16'h0);
    btn_up[0] = 1'b1; steps(28); btn_up[0] = 1'b0;
    probe("p0_y28", 88, 28, GREEN);
    probe("p0_y27", 88, 27, 16'h0);

    // Left edge, then bring P1 over P0 (P0 x 0..7, P1 x 6..13)
    btn_left[0] = 1'b1; steps(100); btn_left[0] = 1'b0;
    probe("p0_x0", 0, 28, GREEN);
    btn_left[1] = 1'b1; steps(14); btn_left[1] = 1'b0;
    probe("ovl_prio", 6, 28, GREEN);
    probe("ovl_p1", 8, 28, BLUE);
    probe("ovl_p1_end", 14, 28, 16'h0);
    check("collide_pre", 32'(is_collide), 32'h0);
    scan(1'b0);
    check("collide_on", 32'(is_collide), 32'h1);

    btn_right[1] = 1'b1; steps(10); btn_right[1] = 1'b0;
    probe("sep_p1", 16, 28, BLUE);
    probe("sep_gap", 15, 28, 16'h0);
    scan(1'b0);
    check("collide_off", 32'(is_collide), 32'h0);

    btn_left[1] = 1'b1; steps(10); btn_left[1] = 1'b0;
    scan(1'b0);
    check("collide_again", 32'(is_collide), 32'h1);

    // Knock P1 down
    pulse_hit1();
    check("hit_down", 32'(player_down), 32'h2);
    probe("down_grey", 10, 28, GREY);
    btn_right[1] = 1'b1; steps(5); btn_right[1] = 1'b0;
    probe("down_nomove", 14, 28, 16'h0);
    scan(1'b0);
    check("down_nocollide", 32'(is_collide), 32'h0);
    check("down_stays", 32'(player_down), 32'h2);

    // Revive: REVIVING after 1 frame, ALIVE after 4 more
    btn_revive[0] = 1'b1;
    scan(1'b0);
    check("rev_f0", 32'(player_reviving), 32'h2);
    check("rev_f0_down", 32'(player_down), 32'h0);
    check("rev_f0_collide", 32'(is_collide), 32'h0);
    probe("rev_col_f0", 10, 28, rev_colour());
    scan(1'b0);
    check("rev_f1", 32'(player_reviving), 32'h2);
    scan(1'b0);
    check("rev_f2", 32'(player_reviving), 32'h2);
    probe("rev_col_f2", 10, 28, rev_colour());
    scan(1'b0);
    check("rev_f3", 32'(player_reviving), 32'h2);
    scan(1'b0);
    check("rev_f4_reviving", 32'(player_reviving), 32'h0);
    check("rev_f4_down", 32'(player_down), 32'h0);
    probe("alive_colour", 10, 28, BLUE);

    // Abort: release revive mid-way
    pulse_hit1();
    check("hit2_down", 32'(player_down), 32'h2);
    scan(1'b0);
    scan(1'b0);
    check("abort_rev", 32'(player_reviving), 32'h2);
    btn_revive[0] = 1'b0;
    scan(1'b0);
    check("abort_down", 32'(player_down), 32'h2);
    check("abort_rev_clr", 32'(player_reviving), 32'h0);

    // Hit coinciding with a frame-boundary transition wins
    btn_revive[0] = 1'b1;
    scan(1'b0);
    check("hw_rev", 32'(player_reviving), 32'h2);
    scan(1'b1);
    check("hw_rev_down", 32'(player_down), 32'h2);
    scan(1'b1);
    check("hw_down_stay", 32'(player_down), 32'h2);
    check("hw_down_norev", 32'(player_reviving), 32'h0);
    scan(1'b0);
    check("hw_rev2", 32'(player_reviving), 32'h2);

    // Reset mid-frame while P1 is REVIVING
    for (int idx = 24 * W; idx < 30 * W; idx++) begin
      pixel_index = 13'(idx);
      tick();
    end
    btn_revive = '0;
    pixel_index = 13'(28 * W + 2);
    reset = 1'b1;
    tick();
    check("mrst_pix", 32'(pixel_data), 32'h0);
    check("mrst_rev", 32'(player_reviving), 32'h0);
    check("mrst_down", 32'(player_down), 32'h0);
    check("mrst_collide", 32'(is_collide), 32'h0);
    reset = 1'b0;
    m_frames = 0;
    pixel_index = '0;
    probe("mrst_p0_lo", 4, 28, GREEN);
    probe("mrst_p0_hi", 11, 35, GREEN);
    probe("mrst_left", 3, 28, 16'h0);
    probe("mrst_gap", 12, 28, 16'h0);
    probe("mrst_p1", 20, 28, BLUE);
    probe("mrst_x0", 0, 28, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
